// File: rtl/pipe_mon_pkg.sv
// Shared types and helpers for the pipeline event monitor.
package pipe_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Readout select width: one slot for the cycle counter plus one per event channel.
  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_event_monitor_evt_counter.sv
// Single monitor counter with enable, synchronous clear and a sticky overflow flag.
module evt_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (cnt == '1) begin
        ovf <= 1'b1;
        cnt <= SATURATE ? '1 : '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_event_monitor.sv
// Windowed performance monitor: one cycle counter plus NUM_EVT qualified event counters.
module pipe_event_monitor
  import pipe_mon_pkg::*;
#(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 64,
  parameter bit SATURATE   = 1'b1,
  localparam int SEL_W     = sel_w(NUM_EVT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               freeze_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] evt_kill_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               running_o,
  output logic               done_o,
  output logic               done_pulse_o,
  output logic [NUM_EVT:0]   ovf_o
);

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt [NUM_EVT+1];
  logic [NUM_EVT:0]     en;
  logic [NUM_EVT-1:0]   qual;
  logic                 at_limit;
  logic                 count_en;
  logic                 complete;
  logic [CNT_W-1:0]     sel_cnt;

  assign qual     = evt_i & ~evt_kill_i;
  assign at_limit = (MAX_CYCLES != 0) && (cnt[0] == LAST_CYC);

  // The HOLD->RUN resume edge counts, so a freeze held N cycles costs exactly N counted
  // cycles; completion outranks freeze, so the final window cycle is always counted.
  assign count_en = !clear_i &&
                    (((state == RUN) && (at_limit || !freeze_i)) ||
                     ((state == HOLD) && !freeze_i));
  assign complete = count_en && at_limit;
  assign en       = {qual & {NUM_EVT{count_en}}, count_en};

  for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
    evt_counter #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en   (en[g]),
      .clr  (clear_i),
      .cnt  (cnt[g]),
      .ovf  (ovf_o[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      running_o    <= 1'b0;
      done_o       <= 1'b0;
      done_pulse_o <= 1'b0;
    end else begin
      done_pulse_o <= 1'b0;
      if (clear_i) begin
        state     <= IDLE;
        running_o <= 1'b0;
        done_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            state     <= RUN;
            running_o <= 1'b1;
          end
          RUN, HOLD: begin
            if (complete) begin
              state        <= DONE;
              running_o    <= 1'b0;
              done_o       <= 1'b1;
              done_pulse_o <= 1'b1;
            end else if (freeze_i) begin
              state     <= HOLD;
              running_o <= 1'b0;
            end else begin
              state     <= RUN;
              running_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: combinational outputs get a default before any conditional write, so no latch is inferred.
  always_comb begin
    sel_cnt = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k)) sel_cnt = cnt[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_o <= '0;
    else       rd_data_o <= sel_cnt;
  end

endmodule

// File: tb/tb_pipe_event_monitor.sv
// Directed bench for pipe_event_monitor: default instance plus two 8-bit unbounded overflow instances.
module tb_pipe_event_monitor;

  localparam int NUM_EVT = 4;
  localparam int SEL_W   = pipe_mon_pkg::sel_w(NUM_EVT);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i, start_i, clear_i, freeze_i;
  logic [NUM_EVT-1:0] evt_i, evt_kill_i;
  logic [SEL_W-1:0]   rd_sel_i;

  logic [31:0]      rd_m;
  logic [7:0]       rd_s, rd_w;
  logic             run_m, done_m, pulse_m;
  logic             run_s, done_s, pulse_s;
  logic             run_w, done_w, pulse_w;
  logic [NUM_EVT:0] ovf_m, ovf_s, ovf_w;

  pipe_event_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(32), .MAX_CYCLES(64), .SATURATE(1'b1)) u_main (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i), .freeze_i(freeze_i),
    .evt_i(evt_i), .evt_kill_i(evt_kill_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_m),
    .running_o(run_m), .done_o(done_m), .done_pulse_o(pulse_m), .ovf_o(ovf_m));

  pipe_event_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(8), .MAX_CYCLES(0), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i), .freeze_i(freeze_i),
    .evt_i(evt_i), .evt_kill_i(evt_kill_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_s),
    .running_o(run_s), .done_o(done_s), .done_pulse_o(pulse_s), .ovf_o(ovf_s));

  pipe_event_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(8), .MAX_CYCLES(0), .SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i), .freeze_i(freeze_i),
    .evt_i(evt_i), .evt_kill_i(evt_kill_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_w),
    .running_o(run_w), .done_o(done_w), .done_pulse_o(pulse_w), .ovf_o(ovf_w));

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected readouts are queued with the select, popped once rd_data_o registers.
  string       tag_q [$];
  int          who_q [$];
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input int who, input logic [63:0] exp, input string tag);
    who_q.push_back(who);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic rd_cycle(input logic [SEL_W-1:0] sel);
    rd_sel_i = sel;
    tick();
    while (exp_q.size() != 0) begin
      int          w;
      logic [63:0] e, o;
      string       t;
      w = who_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = (w == 0) ? 64'(rd_m) : (w == 1) ? 64'(rd_s) : 64'(rd_w);
      check(t, o, e);
    end
  endtask

  task automatic rd(input logic [SEL_W-1:0] sel, input logic [63:0] exp, input string tag);
    expect_rd(0, exp, tag);
    rd_cycle(sel);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; freeze_i = 1'b0;
    evt_i = 4'b0101; evt_kill_i = '0; rd_sel_i = '0;

    // 1: reset with toggling events, then idle must not count
    for (int i = 0; i < 3; i++) begin
      evt_i = ~evt_i;
      start_i = (i == 1);
      tick();
    end
    start_i = 1'b0;
    check("rst_rd_data", 64'(rd_m), 0);
    check("rst_running", 64'(run_m), 0);
    check("rst_done", 64'(done_m), 0);
    check("rst_pulse", 64'(pulse_m), 0);
    check("rst_ovf", 64'(ovf_m), 0);
    rst_i = 1'b0;
    for (int s = 0; s <= NUM_EVT; s++) begin
      evt_i = ~evt_i;
      rd(SEL_W'(s), 0, $sformatf("idle_cnt%0d", s));
    end
    check("idle_running", 64'(run_m), 0);
    evt_i = '0;

    // 2: 64-cycle window, channel 0 on every 3rd run cycle from cycle 1
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("win_running", 64'(run_m), 1);
    for (int k = 1; k <= 64; k++) begin
      evt_i = ((k - 1) % 3 == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (k == 63) check("win_not_done_63", 64'(done_m), 0);
    end
    evt_i = '0;
    check("win_pulse", 64'(pulse_m), 1);
    check("win_done", 64'(done_m), 1);
    check("win_stopped", 64'(run_m), 0);
    tick();
    check("win_pulse_once", 64'(pulse_m), 0);
    check("win_done_level", 64'(done_m), 1);
    rd(0, 64, "win_cycles");
    rd(1, 22, "win_ch0");
    rd(3, 0, "win_ch2");
    rd(5, 0, "win_sel_oob5");
    rd(7, 0, "win_sel_oob7");
    for (int i = 0; i < 10; i++) begin
      evt_i = 4'b1111;
      tick();
    end
    evt_i = '0;
    rd(0, 64, "win_frozen_cycles");
    rd(1, 22, "win_frozen_ch0");
    check("win_done_hold", 64'(done_m), 1);

    // 3: qualifier on channel 1; channel 3 always killed
    do_clear();
    check("clr_done", 64'(done_m), 0);
    rd(0, 0, "clr_cycles");
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      evt_i      = 4'b1010;
      evt_kill_i = (k % 4 == 0) ? 4'b1010 : 4'b1000;
      tick();
    end
    evt_kill_i = '0;
    evt_i      = 4'b0010;
    freeze_i   = 1'b1;
    tick();
    check("qual_hold_running", 64'(run_m), 0);
    rd(2, 15, "qual_ch1");
    rd(4, 0, "qual_ch3_killed");
    rd(0, 20, "qual_cycles");
    freeze_i = 1'b0;
    evt_i    = '0;

    // 4: 8-cycle freeze mid-window delays completion by exactly 8 cycles
    do_clear();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      freeze_i = (k >= 31 && k <= 38);
      evt_i    = freeze_i ? 4'b0011 : 4'b0001;
      tick();
      if (k == 71) check("frz_not_done_71", 64'(done_m), 0);
    end
    freeze_i = 1'b0;
    evt_i    = '0;
    check("frz_pulse_72", 64'(pulse_m), 1);
    rd(0, 64, "frz_cycles");
    rd(1, 64, "frz_ch0");
    rd(2, 0, "frz_ch1_only_frozen");

    // 6: abort with clear and start together, then a fresh window
    do_clear();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      evt_i = 4'b0001;
      tick();
    end
    evt_i   = 4'b0001;
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    evt_i   = '0;
    check("abort_running", 64'(run_m), 0);
    check("abort_ovf", 64'(ovf_m), 0);
    rd(1, 0, "abort_ch0_zero");
    start_i = 1'b0;
    check("restart_running", 64'(run_m), 1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) check("restart_not_done_63", 64'(done_m), 0);
    end
    check("restart_pulse", 64'(pulse_m), 1);
    rd(0, 64, "restart_cycles");

    // 5: 8-bit unbounded overflow, saturating and wrapping
    do_clear();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("ovf_sat_running", 64'(run_s), 1);
    for (int k = 1; k <= 300; k++) begin
      evt_i = 4'b0100;
      tick();
      if (k == 255) check("ovf_wrap_none_at_255", 64'(ovf_w), 0);
      if (k == 256) check("ovf_wrap_set_at_256", 64'(ovf_w), 5'b01001);
    end
    evt_i    = '0;
    freeze_i = 1'b1;
    tick();
    check("ovf_sat_flags", 64'(ovf_s), 5'b01001);
    check("ovf_wrap_flags", 64'(ovf_w), 5'b01001);
    check("ovf_sat_never_done", 64'(done_s), 0);
    check("ovf_wrap_no_pulse", 64'({done_w, pulse_w, pulse_s, run_w}), 0);
    expect_rd(1, 255, "ovf_sat_ch2");
    expect_rd(2, 44, "ovf_wrap_ch2");
    rd_cycle(3);
    expect_rd(1, 255, "ovf_sat_cycles");
    expect_rd(2, 44, "ovf_wrap_cycles");
    rd_cycle(0);
    freeze_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
